// File: rtl/mips_pc_pkg.sv
// Shared definitions for the program-counter stage: FSM state encoding
// and the architectural PC constants.
package mips_pc_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_t;

    localparam logic [31:0] PC_STEP   = 32'd4;
    localparam logic [31:0] TEXT_BASE = 32'h0000_3000;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-PC selection: halt > jr > jmp > branch > sequential.
// Also reports which path won so the caller can update side state.
module pc_target_calc (
    input  logic [31:0] pc,
    input  logic [31:0] pc_plus4,
    input  logic        halt,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        jmp,
    input  logic [25:0] jump_index,
    input  logic        pcsel,
    input  logic [15:0] branch_imm,
    output logic [31:0] next_pc,
    output logic        jr_sel,
    output logic        jmp_sel,
    output logic        br_sel
);

    logic [31:0] branch_off;

    assign branch_off = {{14{branch_imm[15]}}, branch_imm, 2'b00};

    // Priority mux; lower-priority controls are ignored once a higher one wins.
    always_comb begin
        next_pc = pc_plus4;
        jr_sel  = 1'b0;
        jmp_sel = 1'b0;
        br_sel  = 1'b0;
        if (halt) begin
            next_pc = pc;
        end else if (jr) begin
            next_pc = {jr_target[31:2], 2'b00};
            jr_sel  = 1'b1;
        end else if (jmp) begin
            next_pc = {pc_plus4[31:28], jump_index, 2'b00};
            jmp_sel = 1'b1;
        end else if (pcsel) begin
            next_pc = pc_plus4 + branch_off;
            br_sel  = 1'b1;
        end
    end

endmodule

// File: rtl/next_pc_unit.sv
// Program-counter stage: PC register, boot/run/halt sequencing,
// retired-instruction counter and sticky JR misalignment flag.
// Optional macro BRANCH_STATS_EN adds taken_cnt / jump_cnt outputs.
//
// state | meaning
// BOOT  | one cycle after reset, no fetch, PC holds
// RUN   | fetching; PC advances and instructions retire when en=1
// HALT  | syscall halt; frozen until reset
module next_pc_unit
    import mips_pc_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = TEXT_BASE,
    parameter int          IMEM_ADDR_W = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   pcsel,
    input  logic [15:0]            branch_imm,
    input  logic                   jmp,
    input  logic [25:0]            jump_index,
    input  logic                   jr,
    input  logic [31:0]            jr_target,
    input  logic                   halt,
    output logic [31:0]            pc,
    output logic [31:0]            pc_plus4,
    output logic [IMEM_ADDR_W-1:0] imem_addr,
    output logic                   fetch_valid,
    output logic                   halted,
    output logic                   misalign_err,
`ifdef BRANCH_STATS_EN
    output logic [31:0]            taken_cnt,
    output logic [31:0]            jump_cnt,
`endif
    output logic [31:0]            retire_cnt
);

    pc_state_t   state;
    logic [31:0] pc_q;
    logic [31:0] next_pc;
    logic        jr_sel;
    logic        jmp_sel;
    logic        br_sel;
    logic        advance;

    assign pc          = pc_q;
    assign pc_plus4    = pc_q + PC_STEP;
    assign imem_addr   = pc_q[IMEM_ADDR_W+1:2];
    assign fetch_valid = (state == RUN);
    assign halted      = (state == HALT);
    assign advance     = (state == RUN) && en;

    pc_target_calc u_target (
        .pc         (pc_q),
        .pc_plus4   (pc_plus4),
        .halt       (halt),
        .jr         (jr),
        .jr_target  (jr_target),
        .jmp        (jmp),
        .jump_index (jump_index),
        .pcsel      (pcsel),
        .branch_imm (branch_imm),
        .next_pc    (next_pc),
        .jr_sel     (jr_sel),
        .jmp_sel    (jmp_sel),
        .br_sel     (br_sel)
    );

    // State sequencing; reset has absolute priority over stall and halt.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= BOOT;
        end else begin
            case (state)
                BOOT:    state <= RUN;
                RUN:     if (en && halt) state <= HALT;
                HALT:    state <= HALT;
                default: state <= BOOT;
            endcase
        end
    end

    // PC, retire counter and sticky misalignment flag advance only in RUN with en.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            retire_cnt   <= 32'd0;
            misalign_err <= 1'b0;
        end else if (advance) begin
            pc_q       <= next_pc;
            retire_cnt <= retire_cnt + 32'd1;
            if (jr_sel && (jr_target[1:0] != 2'b00)) misalign_err <= 1'b1;
        end
    end

`ifdef BRANCH_STATS_EN
    // Branch/jump statistics, counted on the path actually selected.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            taken_cnt <= 32'd0;
            jump_cnt  <= 32'd0;
        end else if (advance) begin
            if (br_sel)             taken_cnt <= taken_cnt + 32'd1;
            if (jr_sel || jmp_sel)  jump_cnt  <= jump_cnt + 32'd1;
        end
    end
`else
    logic unused_sel;
    assign unused_sel = br_sel ^ jmp_sel;
`endif

endmodule

// File: tb/tb_next_pc_unit.sv
// Self-checking bench for next_pc_unit: directed vector table plus
// randomized traffic against an arithmetic reference model.
module tb_next_pc_unit;

    localparam int IMEM_ADDR_W = 10;
    localparam logic [31:0] RST_PC = 32'h0000_3000;

    logic                   clk;
    logic                   rst_n;
    logic                   en;
    logic                   pcsel;
    logic [15:0]            branch_imm;
    logic                   jmp;
    logic [25:0]            jump_index;
    logic                   jr;
    logic [31:0]            jr_target;
    logic                   halt;
    logic [31:0]            pc;
    logic [31:0]            pc_plus4;
    logic [IMEM_ADDR_W-1:0] imem_addr;
    logic                   fetch_valid;
    logic                   halted;
    logic                   misalign_err;
    logic [31:0]            retire_cnt;
`ifdef BRANCH_STATS_EN
    logic [31:0]            taken_cnt;
    logic [31:0]            jump_cnt;
`endif

    next_pc_unit #(.RESET_PC(RST_PC), .IMEM_ADDR_W(IMEM_ADDR_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .pcsel        (pcsel),
        .branch_imm   (branch_imm),
        .jmp          (jmp),
        .jump_index   (jump_index),
        .jr           (jr),
        .jr_target    (jr_target),
        .halt         (halt),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .imem_addr    (imem_addr),
        .fetch_valid  (fetch_valid),
        .halted       (halted),
        .misalign_err (misalign_err),
`ifdef BRANCH_STATS_EN
        .taken_cnt    (taken_cnt),
        .jump_cnt     (jump_cnt),
`endif
        .retire_cnt   (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] m_pc, m_ret, m_taken, m_jumps;
    logic        m_boot, m_halt, m_mis;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_step();
        logic [31:0] off;
        if (!rst_n) begin
            m_pc = RST_PC; m_ret = 0; m_mis = 0; m_boot = 1; m_halt = 0;
            m_taken = 0; m_jumps = 0;
        end else if (m_boot) begin
            m_boot = 0;
        end else if (!m_halt && en) begin
            m_ret = m_ret + 1;
            if (halt) begin
                m_halt = 1;
            end else if (jr) begin
                m_pc = jr_target & 32'hFFFF_FFFC;
                if (jr_target % 4 != 0) m_mis = 1;
                m_jumps = m_jumps + 1;
            end else if (jmp) begin
                m_pc = ((m_pc + 4) & 32'hF000_0000) | (32'(jump_index) * 4);
                m_jumps = m_jumps + 1;
            end else if (pcsel) begin
                off = 32'(int'($signed(branch_imm)) * 4);
                m_pc = m_pc + 4 + off;
                m_taken = m_taken + 1;
            end else begin
                m_pc = m_pc + 4;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("pc", pc, m_pc);
        check("pc_plus4", pc_plus4, m_pc + 32'd4);
        check("imem_addr", 32'(imem_addr), (m_pc / 4) % (1 << IMEM_ADDR_W));
        check("fetch_valid", 32'(fetch_valid), 32'(!m_boot && !m_halt));
        check("halted", 32'(halted), 32'(m_halt));
        check("misalign_err", 32'(misalign_err), 32'(m_mis));
        check("retire_cnt", retire_cnt, m_ret);
`ifdef BRANCH_STATS_EN
        check("taken_cnt", taken_cnt, m_taken);
        check("jump_cnt", jump_cnt, m_jumps);
`endif
    endtask

    task automatic drive(input logic e, input logic ps, input logic [15:0] imm,
                         input logic j, input logic [25:0] idx,
                         input logic r, input logic [31:0] rt, input logic h);
        en = e; pcsel = ps; branch_imm = imm; jmp = j; jump_index = idx;
        jr = r; jr_target = rt; halt = h;
    endtask

    // Reset for one edge, then the BOOT cycle (with en and pcsel asserted to show they are ignored).
    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 16'h0010, 1'b0, 26'd0, 1'b0, 32'd0, 1'b0);
        cycle();
        check("rst_pc", pc, 32'h0000_3000);
        check("rst_fetch_valid", 32'(fetch_valid), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        rst_n = 1'b1;
        cycle();
        check("boot_pc_hold", pc, 32'h0000_3000);
        check("boot_to_run", 32'(fetch_valid), 32'd1);
    endtask

    typedef struct {
        logic        rst_before;
        logic        en;
        logic        pcsel;
        logic [15:0] imm;
        logic        jmp;
        logic [25:0] idx;
        logic        jr;
        logic [31:0] jrt;
        logic        halt;
        logic [31:0] e_pc;
        logic [31:0] e_ret;
        logic        e_mis;
        logic        e_halt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rb, input logic e, input logic ps, input logic [15:0] imm,
                                input logic j, input logic [25:0] idx, input logic r,
                                input logic [31:0] rt, input logic h, input logic [31:0] epc,
                                input logic [31:0] eret, input logic emis, input logic ehalt);
        vec_t v;
        v.rst_before = rb; v.en = e; v.pcsel = ps; v.imm = imm; v.jmp = j; v.idx = idx;
        v.jr = r; v.jrt = rt; v.halt = h; v.e_pc = epc; v.e_ret = eret; v.e_mis = emis;
        v.e_halt = ehalt;
        return v;
    endfunction

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 16'd0, 1'b0, 26'd0, 1'b0, 32'd0, 1'b0);
        m_pc = RST_PC; m_ret = 0; m_mis = 0; m_boot = 1; m_halt = 0; m_taken = 0; m_jumps = 0;

        //            rb e  ps imm      j  idx        r  jrt            h  pc             ret mis hlt
        vecs.push_back(mk(1, 1, 0, 16'h0000, 0, 26'h0,     0, 32'h0,         0, 32'h0000_3004, 1,  0, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 26'h0,     0, 32'h0,         0, 32'h0000_3008, 2,  0, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 26'h0,     0, 32'h0,         0, 32'h0000_300C, 3,  0, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 26'h0,     0, 32'h0,         0, 32'h0000_3010, 4,  0, 0));
        vecs.push_back(mk(0, 1, 1, 16'hFFFC, 0, 26'h0,     0, 32'h0,         0, 32'h0000_3004, 5,  0, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 1, 26'hC04,   0, 32'h0,         0, 32'h0000_3010, 6,  0, 0));
        vecs.push_back(mk(0, 1, 1, 16'h0003, 0, 26'h0,     0, 32'h0,         0, 32'h0000_3020, 7,  0, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 1, 26'hC00,   0, 32'h0,         0, 32'h0000_3000, 8,  0, 0));
        vecs.push_back(mk(0, 1, 1, 16'h0010, 1, 26'hC10,   0, 32'h0,         0, 32'h0000_3040, 9,  0, 0));
        vecs.push_back(mk(0, 1, 1, 16'h0010, 1, 26'hC10,   1, 32'h0000_3102, 0, 32'h0000_3100, 10, 1, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 26'h0,     1, 32'h0000_3200, 0, 32'h0000_3200, 11, 1, 0));
        vecs.push_back(mk(0, 0, 1, 16'h0040, 0, 26'h0,     0, 32'h0,         0, 32'h0000_3200, 11, 1, 0));
        vecs.push_back(mk(0, 0, 1, 16'h0040, 0, 26'h0,     0, 32'h0,         0, 32'h0000_3200, 11, 1, 0));
        vecs.push_back(mk(0, 0, 1, 16'h0040, 0, 26'h0,     0, 32'h0,         0, 32'h0000_3200, 11, 1, 0));
        vecs.push_back(mk(0, 1, 1, 16'h0040, 1, 26'h5,     1, 32'h0000_4000, 1, 32'h0000_3200, 12, 1, 1));
        vecs.push_back(mk(0, 1, 1, 16'h0040, 0, 26'h0,     0, 32'h0,         0, 32'h0000_3200, 12, 1, 1));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 26'h0,     1, 32'h0000_5000, 0, 32'h0000_3200, 12, 1, 1));
        vecs.push_back(mk(1, 1, 1, 16'h0010, 1, 26'h7,     1, 32'h0000_3001, 1, 32'h0000_3000, 1,  0, 1));
        vecs.push_back(mk(1, 1, 0, 16'h0000, 0, 26'h0,     1, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 1,  0, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 26'h0,     0, 32'h0,         0, 32'h0000_0000, 2,  0, 0));
        vecs.push_back(mk(0, 1, 1, 16'h8000, 0, 26'h0,     0, 32'h0,         0, 32'hFFFE_0004, 3,  0, 0));
        vecs.push_back(mk(0, 1, 1, 16'h7FFF, 0, 26'h0,     0, 32'h0,         0, 32'h0000_0004, 4,  0, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 1, 26'h3FFFFFF, 0, 32'h0,       0, 32'h0FFF_FFFC, 5,  0, 0));

        repeat (2) @(posedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst_before) do_reset();
            drive(vecs[i].en, vecs[i].pcsel, vecs[i].imm, vecs[i].jmp, vecs[i].idx,
                  vecs[i].jr, vecs[i].jrt, vecs[i].halt);
            cycle();
            check($sformatf("vec%0d_pc", i), pc, vecs[i].e_pc);
            check($sformatf("vec%0d_retire", i), retire_cnt, vecs[i].e_ret);
            check($sformatf("vec%0d_misalign", i), 32'(misalign_err), 32'(vecs[i].e_mis));
            check($sformatf("vec%0d_halted", i), 32'(halted), 32'(vecs[i].e_halt));
        end

`ifdef BRANCH_STATS_EN
        do_reset();
        drive(1, 1, 16'h0004, 0, 26'h0, 0, 32'h0, 0); cycle();
        drive(1, 1, 16'h0004, 0, 26'h0, 0, 32'h0, 0); cycle();
        drive(1, 1, 16'h0004, 0, 26'h0, 1, 32'h0000_3800, 0); cycle();
        drive(1, 1, 16'h0004, 1, 26'h0, 1, 32'h0000_3800, 1); cycle();
        check("stats_taken", taken_cnt, 32'd2);
        check("stats_jump", jump_cnt, 32'd1);
        check("stats_retire", retire_cnt, 32'd4);
`endif

        // Randomized traffic against the reference model, including mid-stall/mid-halt resets.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rst_n      = ($urandom_range(0, 59) != 0);
            en         = ($urandom_range(0, 3) != 0);
            halt       = ($urandom_range(0, 39) == 0);
            jr         = ($urandom_range(0, 7) == 0);
            jmp        = ($urandom_range(0, 7) == 0);
            pcsel      = ($urandom_range(0, 2) == 0);
            branch_imm = 16'($urandom);
            jump_index = 26'($urandom);
            jr_target  = $urandom;
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
